// File: rtl/logic_pipe_unit.sv
// Two-stage pipelined bitwise logic unit with valid/ready handshakes on both sides and an output-transfer counter.
// Define LOGIC_PIPE_FLAGS_EN to register zero/parity flags with the result; otherwise both flags are tied to 0.
module logic_pipe_unit #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic [2:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] result,
  output logic             zero,
  output logic             parity,
  output logic [CNT_W-1:0] op_count
);

  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

  logic             s1_valid_r;
  logic [WIDTH-1:0] a_r;
  logic [WIDTH-1:0] b_r;
  logic [2:0]       op_r;
  logic             out_valid_r;
  logic [WIDTH-1:0] result_r;
  logic [CNT_W-1:0] op_count_r;
  logic             adv2_s;
  logic             in_xfer_s;
  logic             out_xfer_s;
  logic [WIDTH-1:0] calc_s;

  // Handshake qualifiers; in_ready never looks at in_valid
  always_comb begin
    adv2_s     = s1_valid_r & (~out_valid_r | out_ready);
    in_ready   = ~s1_valid_r | adv2_s;
    in_xfer_s  = in_valid & in_ready;
    out_xfer_s = out_valid_r & out_ready;
  end

  // Bitwise operation selected by the staged opcode
  always_comb begin
    calc_s = b_r;
    case (op_r)
      3'b000:  calc_s = a_r & b_r;
      3'b001:  calc_s = a_r | b_r;
      3'b010:  calc_s = a_r ^ b_r;
      3'b011:  calc_s = ~(a_r ^ b_r);
      3'b100:  calc_s = ~(a_r & b_r);
      3'b101:  calc_s = ~(a_r | b_r);
      3'b110:  calc_s = ~a_r;
      3'b111:  calc_s = b_r;
      default: calc_s = b_r;
    endcase
  end

  // Stage 1 operand capture
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_r <= 1'b0;
      a_r        <= {WIDTH{1'b0}};
      b_r        <= {WIDTH{1'b0}};
      op_r       <= 3'b000;
    end else if (in_xfer_s) begin
      s1_valid_r <= 1'b1;
      a_r        <= A;
      b_r        <= B;
      op_r       <= op;
    end else if (adv2_s) begin
      s1_valid_r <= 1'b0;
    end
  end

  // Stage 2 result register; holds exactly while stalled
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_r <= 1'b0;
      result_r    <= {WIDTH{1'b0}};
    end else if (adv2_s) begin
      out_valid_r <= 1'b1;
      result_r    <= calc_s;
    end else if (out_xfer_s) begin
      out_valid_r <= 1'b0;
    end
  end

  // Completed-transfer counter, wraps naturally
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      op_count_r <= {CNT_W{1'b0}};
    end else if (out_xfer_s) begin
      op_count_r <= op_count_r + CNT_ONE;
    end
  end

`ifdef LOGIC_PIPE_FLAGS_EN
  function automatic logic parity_of(input logic [WIDTH-1:0] v);
    return ^v;
  endfunction

  logic zero_r;
  logic parity_r;

  // Flags computed from the same value loaded into result
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      zero_r   <= 1'b0;
      parity_r <= 1'b0;
    end else if (adv2_s) begin
      zero_r   <= (calc_s == {WIDTH{1'b0}});
      parity_r <= parity_of(calc_s);
    end
  end

  assign zero   = zero_r;
  assign parity = parity_r;
`else
  assign zero   = 1'b0;
  assign parity = 1'b0;
`endif

  assign out_valid = out_valid_r;
  assign result    = result_r;
  assign op_count  = op_count_r;

endmodule
